onehot_index_encoder: RTL and testbench



---
 rtl/onehot_enc_pkg.sv | 18 +
 rtl/onehot_index_encoder_ffs_encode.sv | 25 ++
 rtl/onehot_index_encoder.sv | 156 +++++++++++++++
 tb/tb_onehot_index_encoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onehot_enc_pkg.sv
// Shared defaults, FSM state type and width helper for the one-hot index encoder.
package onehot_enc_pkg;

  localparam int N_DEF   = 1024;
  localparam int GRP_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // Index width for an n-entry space; never narrower than one bit.
  function automatic int clog2w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot_index_encoder_ffs_encode.sv
// Combinational find-first-set: lowest set index, any-set and exactly-one-set flags.
module ffs_encode
  import onehot_enc_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int IW    = clog2w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             any_o,
  output logic [IW-1:0]    idx_o,
  output logic             only_one_o
);

  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

  assign any_o      = |vec_i;
  // Clearing the lowest set bit leaves zero only when a single bit was set.
  assign only_one_o = any_o && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/onehot_index_encoder.sv
// Serially emits the index of every set bit of a loaded vector, lowest first.
// Optional pop_cnt output enabled by ONEHOT_INDEX_ENCODER_POPCOUNT_EN.
module onehot_index_encoder
  import onehot_enc_pkg::*;
#(
  parameter  int N   = N_DEF,
  parameter  int GRP = GRP_DEF,
  localparam int W   = clog2w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N-1:0] load_vec,
  output logic         idx_valid,
  input  logic         idx_ready,
  output logic [W-1:0] idx,
  output logic         idx_last,
  output logic         done,
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
  output logic         busy,
  output logic [W:0]   pop_cnt
`else
  output logic         busy
`endif
);

  localparam int NG  = N / GRP;
  localparam int IW1 = clog2w(NG);
  localparam int IW2 = clog2w(GRP);

  state_e         state_q;
  logic [N-1:0]   pend_q;
  logic [W-1:0]   idx_q;
  logic           last_q;
  logic           vld_q;
  logic           done_q;

  logic [N-1:0]   src;
  logic [NG-1:0]  grp_any;
  logic           l1_any, l2_any, grp_one, bit_one;
  logic [IW1-1:0] grp_idx;
  logic [IW2-1:0] bit_idx;
  logic [GRP-1:0] grp_bits;
  logic           any_src, last_nxt;
  logic [W-1:0]   idx_nxt;
  logic [N-1:0]   clr;

  // In IDLE the search runs on the incoming vector so the first index is ready at t+1.
  assign src = (state_q == IDLE) ? load_vec : pend_q;

  always_comb begin
    for (int g = 0; g < NG; g++) grp_any[g] = |src[g*GRP +: GRP];
  end

  ffs_encode #(.WIDTH(NG)) u_ffs_grp (
    .vec_i      (grp_any),
    .any_o      (l1_any),
    .idx_o      (grp_idx),
    .only_one_o (grp_one)
  );

  always_comb begin
    grp_bits = '0;
    for (int g = 0; g < NG; g++) begin
      if (int'(grp_idx) == g) grp_bits = src[g*GRP +: GRP];
    end
  end

  ffs_encode #(.WIDTH(GRP)) u_ffs_bit (
    .vec_i      (grp_bits),
    .any_o      (l2_any),
    .idx_o      (bit_idx),
    .only_one_o (bit_one)
  );

  assign any_src  = l1_any && l2_any;
  assign last_nxt = grp_one && bit_one;
  assign idx_nxt  = W'(int'(grp_idx) * GRP + int'(bit_idx));
  assign clr      = N'(1) << idx_nxt;

`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
  logic [W:0] pop_q;

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int i = 0; i < N; i++) c = c + (W+1)'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)                              pop_q <= '0;
    else if (state_q == IDLE && load_valid) pop_q <= popcnt(load_vec);
  end

  assign pop_cnt = pop_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            if (any_src) begin
              pend_q  <= src & ~clr;
              idx_q   <= idx_nxt;
              last_q  <= last_nxt;
              vld_q   <= 1'b1;
              state_q <= RUN;
            end else begin
              pend_q  <= '0;
              done_q  <= 1'b1;
              state_q <= FLUSH;
            end
          end
        end
        RUN: begin
          if (!vld_q || idx_ready) begin
            if (any_src) begin
              pend_q <= src & ~clr;
              idx_q  <= idx_nxt;
              last_q <= last_nxt;
              vld_q  <= 1'b1;
            end else begin
              // Final index just accepted with nothing left to load.
              vld_q <= 1'b0;
              if (vld_q) begin
                done_q  <= 1'b1;
                state_q <= FLUSH;
              end
            end
          end
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign idx_valid  = vld_q;
  assign idx        = idx_q;
  assign idx_last   = last_q;
  assign done       = done_q;

endmodule

// File: tb/tb_onehot_index_encoder.sv
// Scoreboard bench for onehot_index_encoder: stimulus pushes expected indices, a monitor pops on handshakes.
module tb_onehot_index_encoder;

  localparam int N = 1024;
  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_valid = 1'b0;
  logic         idx_ready = 1'b0;
  logic [N-1:0] load_vec = '0;
  logic         load_ready, idx_valid, idx_last, done, busy;
  logic [W-1:0] idx;
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
  logic [W:0]   pop_cnt;
`endif

  onehot_index_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_vec   (load_vec),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx        (idx),
    .idx_last   (idx_last),
    .done       (done),
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
    .busy       (busy),
    .pop_cnt    (pop_cnt)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] i;
    logic         l;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  int           done_cnt = 0;
  int           hs_cnt = 0;
  logic         stall_prev = 1'b0;
  logic [W-1:0] stall_idx = '0;
  logic         stall_last = 1'b0;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected order: ascending bit positions, last flag on the highest one.
  task automatic push_vec(input logic [N-1:0] v);
    int hi;
    exp_t e;
    hi = -1;
    for (int i = 0; i < N; i++) if (v[i]) hi = i;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        e.i = W'(i);
        e.l = (i == hi);
        q.push_back(e);
      end
    end
  endtask

  task automatic load(input logic [N-1:0] v);
    chk("load_ready_before_load", load_ready, 1);
    push_vec(v);
    load_vec   = v;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  // Monitor: handshakes pop the scoreboard, stalls must hold idx/idx_last.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (stall_prev) begin
        chk("stall_idx_stable", idx, stall_idx);
        chk("stall_last_stable", idx_last, stall_last);
      end
      stall_prev = idx_valid && !idx_ready;
      stall_idx  = idx;
      stall_last = idx_last;
      if (idx_valid && idx_ready) begin
        exp_t e;
        hs_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_index", idx, -1);
        end else begin
          e = q.pop_front();
          chk("sb_idx", idx, e.i);
          chk("sb_last", idx_last, e.l);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] v;
    int h0, d0;

    rst = 1'b1;
    repeat (2) tick();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_idx_valid", idx_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_idx_last", idx_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
    chk("rst_pop_cnt", pop_cnt, 0);
`endif
    rst = 1'b0;
    tick();

    // Bits {0,5,1023}, consumer always ready.
    v = '0; v[0] = 1'b1; v[5] = 1'b1; v[1023] = 1'b1;
    idx_ready = 1'b1;
    load(v);
    chk("t1_valid_t1", idx_valid, 1);
    chk("t1_idx0", idx, 0);
    chk("t1_busy", busy, 1);
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
    chk("t1_pop_cnt", pop_cnt, 3);
`endif
    tick();
    chk("t1_idx5", idx, 5);
    chk("t1_last5", idx_last, 0);
    tick();
    chk("t1_idx1023", idx, 1023);
    chk("t1_last1023", idx_last, 1);
    tick();
    chk("t1_done", done, 1);
    chk("t1_valid_after", idx_valid, 0);
    chk("t1_ready_in_flush", load_ready, 0);
    tick();
    chk("t1_done_one_cycle", done, 0);
    chk("t1_ready_back", load_ready, 1);
    chk("t1_done_cnt", done_cnt, 1);

    // Same vector with ready pattern 1,0,0,1,1.
    h0 = hs_cnt;
    load(v);
    idx_ready = 1'b1;
    tick();
    idx_ready = 1'b0;
    chk("t2_idx5_a", idx, 5);
    tick();
    chk("t2_idx5_b", idx, 5);
    tick();
    chk("t2_idx5_c", idx, 5);
    idx_ready = 1'b1;
    tick();
    chk("t2_idx1023", idx, 1023);
    wait_done("t2_done_seen", 10);
    tick();
    chk("t2_handshakes", hs_cnt - h0, 3);
    chk("t2_done_cnt", done_cnt, 2);

    // All-zero vector.
    load('0);
    chk("t3_no_valid", idx_valid, 0);
    chk("t3_done_t1", done, 1);
    chk("t3_ready_low", load_ready, 0);
    tick();
    chk("t3_ready_t2", load_ready, 1);
    chk("t3_done_low", done, 0);
    chk("t3_done_cnt", done_cnt, 3);

    // All ones.
    h0 = hs_cnt;
    load('1);
`ifdef ONEHOT_INDEX_ENCODER_POPCOUNT_EN
    chk("t4_pop_cnt", pop_cnt, 1024);
`endif
    wait_done("t4_done_seen", 1100);
    tick();
    chk("t4_handshakes", hs_cnt - h0, 1024);
    chk("t4_done_cnt", done_cnt, 4);
    chk("t4_sb_empty", q.size(), 0);

    // Reset in the middle of RUN.
    v = '0; v[3] = 1'b1; v[700] = 1'b1;
    load(v);
    chk("t5_idx3", idx, 3);
    tick();
    chk("t5_idx700", idx, 700);
    idx_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    chk("t5_valid_dropped", idx_valid, 0);
    chk("t5_ready_after_rst", load_ready, 1);
    chk("t5_busy_after_rst", busy, 0);
    d0 = done_cnt;
    repeat (3) tick();
    chk("t5_no_done", done_cnt, d0);
    idx_ready = 1'b1;
    v = '0; v[9] = 1'b1;
    load(v);
    chk("t5_idx9", idx, 9);
    chk("t5_last9", idx_last, 1);
    wait_done("t5_done_seen", 10);
    tick();

    // load_valid held with another vector during RUN must be ignored.
    h0 = hs_cnt;
    v = '0; v[2] = 1'b1; v[4] = 1'b1;
    load(v);
    load_vec = '0; load_vec[7] = 1'b1;
    load_valid = 1'b1;
    chk("t6_idx2", idx, 2);
    tick();
    chk("t6_idx4", idx, 4);
    chk("t6_last4", idx_last, 1);
    tick();
    chk("t6_done", done, 1);
    load_valid = 1'b0;
    tick();
    chk("t6_handshakes", hs_cnt - h0, 2);
    chk("t6_no_valid", idx_valid, 0);

    chk("final_sb_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
